// File: rtl/countgen_mc.sv
// countgen_mc: multi-channel pin counter / square-wave generator on a 32-bit WISHBONE slave.
//
// Ports:
//   clk_i        sole clock
//   rst_i        synchronous reset, active-low
//   cyc_i/stb_i  bus cycle / strobe
//   adr_i[7:0]   word address; [7]=0 global regs, [7]=1 channel regs (ch=[6:2], reg=[1:0])
//   we_i         write enable
//   dat_i[31:0]  write data
//   dat_o[31:0]  read data, valid with ack_o
//   ack_o        registered single-cycle acknowledge
//   irq_o        level interrupt, |(OVF & IRQEN)
//   countgen_io  channel pins, driven by the generator when DIR=1, else high-Z
module countgen_mc #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic [7:0]        adr_i,
  input  logic              we_i,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o,
  output logic              ack_o,
  output logic              irq_o,
  inout  wire  [NUM_CH-1:0] countgen_io
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic              r_ack;
  logic [31:0]       r_dat;
  logic [NUM_CH-1:0] r_dir, r_ovf, r_irqen, r_gen;
  logic [NUM_CH-1:0] r_sync1, r_sync2, r_prev, r_rise, r_fall;
  logic [2:0]        r_mode   [NUM_CH];
  logic [CNT_W-1:0]  r_period [NUM_CH];
  logic [CNT_W-1:0]  r_count  [NUM_CH];
  logic [CNT_W-1:0]  r_snap   [NUM_CH];
  logic [CNT_W-1:0]  r_div    [NUM_CH];

  logic              w_acc, w_wr, w_glb_wr;
  logic              w_wr_dir, w_wr_irqen;
  logic [NUM_CH-1:0] w_snap, w_clr, w_ovf_clr;
  logic [NUM_CH-1:0] w_chsel, w_wr_mode, w_wr_period, w_wr_count;
  logic [NUM_CH-1:0] w_src, w_inc, w_wrap, w_gen_en;
  logic [31:0]       w_rdata;
  logic              w_unused_dat;

  assign ack_o = r_ack;
  assign dat_o = r_dat;
  assign irq_o = |(r_ovf & r_irqen);

  // An access is accepted only while ack is low, giving one ack per strobe.
  assign w_acc    = cyc_i & stb_i & ~r_ack;
  assign w_wr     = w_acc & we_i;
  assign w_glb_wr = w_wr & ~adr_i[7];

  assign w_wr_dir   = w_glb_wr & (adr_i[6:0] == 7'd0);
  assign w_wr_irqen = w_glb_wr & (adr_i[6:0] == 7'd4);
  assign w_snap     = (w_glb_wr && adr_i[6:0] == 7'd1) ? dat_i[NUM_CH-1:0] : '0;
  assign w_clr      = (w_glb_wr && adr_i[6:0] == 7'd2) ? dat_i[NUM_CH-1:0] : '0;
  assign w_ovf_clr  = (w_glb_wr && adr_i[6:0] == 7'd3) ? dat_i[NUM_CH-1:0] : '0;

  assign w_unused_dat = ^dat_i;

  // Loopback: an output channel counts its own generator, not the pad.
  assign w_src = (r_dir & r_gen) | (~r_dir & countgen_io);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pin
    assign countgen_io[g] = r_dir[g] ? r_gen[g] : 1'bz;
  end

  always_comb begin
    w_chsel     = '0;
    w_wr_mode   = '0;
    w_wr_period = '0;
    w_wr_count  = '0;
    w_inc       = '0;
    w_wrap      = '0;
    w_gen_en    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_chsel[c]     = adr_i[7] & (adr_i[6:2] == 5'(c));
      w_wr_mode[c]   = w_wr & w_chsel[c] & (adr_i[1:0] == 2'd0);
      w_wr_period[c] = w_wr & w_chsel[c] & (adr_i[1:0] == 2'd1);
      w_wr_count[c]  = w_wr & w_chsel[c] & (adr_i[1:0] == 2'd2);
      w_inc[c]       = (r_mode[c][0] & r_rise[c]) | (r_mode[c][1] & r_fall[c]);
      // An increment pre-empted by clear or bus write cannot overflow.
      w_wrap[c]      = w_inc[c] & ~w_clr[c] & ~w_wr_count[c] & (r_count[c] == '1);
      w_gen_en[c]    = r_mode[c][2] & (r_period[c] != '0);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (!adr_i[7]) begin
      case (adr_i[6:0])
        7'd0:    w_rdata[NUM_CH-1:0] = r_dir;
        7'd3:    w_rdata[NUM_CH-1:0] = r_ovf;
        7'd4:    w_rdata[NUM_CH-1:0] = r_irqen;
        default: w_rdata = '0;
      endcase
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_chsel[c]) begin
          case (adr_i[1:0])
            2'd0:    w_rdata[2:0]       = r_mode[c];
            2'd1:    w_rdata[CNT_W-1:0] = r_period[c];
            2'd2:    w_rdata[CNT_W-1:0] = r_count[c];
            default: w_rdata[CNT_W-1:0] = r_snap[c];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_dir   <= '0;
      r_ovf   <= '0;
      r_irqen <= '0;
      r_gen   <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_mode[c]   <= '0;
        r_period[c] <= '0;
        r_count[c]  <= '0;
        r_snap[c]   <= '0;
        r_div[c]    <= '0;
      end
    end else begin
      r_ack <= w_acc;
      if (w_acc) r_dat <= w_rdata;
      if (w_wr_dir) r_dir <= dat_i[NUM_CH-1:0];
      if (w_wr_irqen) r_irqen <= dat_i[NUM_CH-1:0];

      // Set wins over a same-cycle write-1-to-clear.
      r_ovf <= (r_ovf & ~w_ovf_clr) | w_wrap;

      // Two sync flops, a previous-value flop, then registered edge flags.
      r_sync1 <= w_src;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_rise  <= r_sync2 & ~r_prev;
      r_fall  <= ~r_sync2 & r_prev;

      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr_mode[c]) r_mode[c] <= dat_i[2:0];
        if (w_wr_period[c]) r_period[c] <= dat_i[CNT_W-1:0];
        if (w_snap[c]) r_snap[c] <= r_count[c];

        if (w_clr[c]) begin
          r_count[c] <= '0;
        end else if (w_wr_count[c]) begin
          r_count[c] <= dat_i[CNT_W-1:0];
        end else if (w_inc[c]) begin
          r_count[c] <= r_count[c] + CntOne;
        end

        if (!w_gen_en[c]) begin
          r_div[c] <= '0;
          r_gen[c] <= 1'b0;
        end else if (w_wr_period[c]) begin
          r_div[c] <= '0;
        end else if (r_div[c] == r_period[c] - CntOne) begin
          r_div[c] <= '0;
          r_gen[c] <= ~r_gen[c];
        end else begin
          r_div[c] <= r_div[c] + CntOne;
        end
      end
    end
  end

endmodule

// File: tb/tb_countgen_mc.sv
// tb_countgen_mc: directed self-checking bench for countgen_mc (NUM_CH=8, CNT_W=8).
module tb_countgen_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [7:0]  adr = '0;
  logic [31:0] dat = '0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        irq_o;
  wire  [7:0]  pins;
  logic [7:0]  tb_oe  = 8'b0001_1100;
  logic [7:0]  tb_val = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 8; g++) begin : g_drv
    assign pins[g] = tb_oe[g] ? tb_val[g] : 1'bz;
  end

  countgen_mc #(
    .NUM_CH(8),
    .CNT_W (8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cyc_i      (cyc),
    .stb_i      (stb),
    .adr_i      (adr),
    .we_i       (we),
    .dat_i      (dat),
    .dat_o      (dat_o),
    .ack_o      (ack_o),
    .irq_o      (irq_o),
    .countgen_io(pins)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns one cycle after the write took effect (the ack edge).
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    @(posedge clk); #1;
    d = dat_o;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic settle();
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v, snap_v;
    logic [1:0]  modes [4];
    logic [31:0] exp_cnt [4];
    modes   = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_cnt = '{32'd5, 32'd5, 32'd10, 32'd0};

    // Reset and bus handshake
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 8'h00;
    check("ack_before", 32'(ack_o), 32'd0);
    @(posedge clk); #1;
    check("ack_high", 32'(ack_o), 32'd1);
    check("rd_dir", dat_o, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(ack_o), 32'd0);
    bus_read(8'h80, v); check("rd_mode0", v, 32'd0);
    bus_read(8'h82, v); check("rd_count0", v, 32'd0);
    bus_read(8'hFC, v); check("rd_ch31", v, 32'd0);
    bus_read(8'h05, v); check("rd_unmapped", v, 32'd0);
    bus_write(8'hFE, 32'h33);
    bus_read(8'h9E, v); check("ch31_no_alias", v, 32'd0);

    // Generator on ch0
    bus_write(8'h00, 32'h01);
    bus_write(8'h80, 32'h4);
    bus_write(8'h81, 32'd3);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      check($sformatf("gen_k%0d", k), {31'b0, pins[0]}, 32'((k / 3) % 2));
    end
    bus_write(8'h81, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("gen_stop", {31'b0, pins[0]}, 32'd0);
    end

    // Edge modes on pin 2
    bus_write(8'h00, 32'h00);
    for (int m = 0; m < 4; m++) begin
      bus_write(8'h88, {30'b0, modes[m]});
      bus_write(8'h02, 32'h04);
      for (int p = 0; p < 5; p++) begin
        tb_val[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tb_val[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      settle();
      bus_read(8'h8A, v);
      check($sformatf("edge_mode%0d", modes[m]), v, exp_cnt[m]);
    end

    // Loopback and snapshot on ch1
    bus_write(8'h00, 32'h02);
    bus_write(8'h84, 32'h5);
    bus_write(8'h85, 32'd2);
    repeat (40) @(posedge clk);
    bus_write(8'h01, 32'h02);
    bus_read(8'h87, snap_v);
    check("snap_range", 32'(snap_v >= 9 && snap_v <= 10), 32'd1);
    repeat (10) @(posedge clk);
    bus_read(8'h86, v);
    check("count_past_snap", 32'(v > snap_v), 32'd1);

    // Overflow, IRQ and increment latency on ch3
    bus_write(8'h8C, 32'h1);
    bus_write(8'h8E, 32'h1FF);
    bus_read(8'h8E, v); check("count_trunc", v, 32'hFF);
    bus_write(8'h04, 32'h08);
    check("irq_idle", 32'(irq_o), 32'd0);
    tb_val[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("lat_n%0d", k), 32'(irq_o), 32'd0);
    end
    @(posedge clk); #1;
    check("lat_n3", 32'(irq_o), 32'd1);
    bus_read(8'h8E, v); check("wrap_count", v, 32'h00);
    bus_read(8'h03, v); check("ovf_set", v, 32'h08);
    bus_write(8'h03, 32'h08);
    check("irq_cleared", 32'(irq_o), 32'd0);
    bus_read(8'h03, v); check("ovf_cleared", v, 32'h00);
    tb_val[3] = 1'b0;

    // Same-cycle collisions on ch4 (edge at N lands at N+3 = write edge)
    bus_write(8'h90, 32'h1);
    bus_write(8'h92, 32'h5);
    tb_val[4] = 1'b1;
    repeat (2) @(posedge clk);
    bus_write(8'h02, 32'h10);
    bus_read(8'h92, v); check("clr_vs_edge", v, 32'h0);
    tb_val[4] = 1'b0;
    settle();
    tb_val[4] = 1'b1;
    repeat (2) @(posedge clk);
    bus_write(8'h92, 32'h10);
    bus_read(8'h92, v); check("wr_vs_edge", v, 32'h10);
    tb_val[4] = 1'b0;
    settle();
    bus_write(8'h92, 32'h7);
    tb_val[4] = 1'b1;
    repeat (2) @(posedge clk);
    bus_write(8'h01, 32'h10);
    bus_read(8'h93, v); check("snap_vs_edge", v, 32'h7);
    bus_read(8'h92, v); check("count_after_snap", v, 32'h8);
    tb_val[4] = 1'b0;
    settle();

    // Reset in the middle of a transfer
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h92; dat = 32'h55;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ack", 32'(ack_o), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b1;
    bus_read(8'h92, v); check("rst_mid_count", v, 32'h0);
    bus_read(8'h00, v); check("rst_mid_dir", v, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/countgen_mc.md
Name: countgen_mc

Overview:
Multi-channel, parametrised pin counter/generator behind a 32-bit WISHBONE slave.
Each channel drives a programmable square wave or counts edges on its bidirectional pin.
Per-channel features: edge-select modes, atomic snapshot/clear, and sticky overflow with interrupt.
Sits on the peripheral WISHBONE bus and replaces single-mode counter/generator blocks.

Parameters:
NUM_CH, 8, number of channels/pins (1..32)
CNT_W, 32, counter and period register width (8..32); narrower values read zero-extended to 32 bits

Ports:
clk_i  input  1  WISHBONE clock, sole clock
rst_i  input  1  synchronous reset, active-low
cyc_i  input  1  bus cycle
stb_i  input  1  strobe
adr_i  input  8  word address
we_i  input  1  write enable
dat_i  input  32  write data
dat_o  output  32  read data, valid with ack_o
ack_o  output  1  registered bus acknowledge
irq_o  output  1  level interrupt: |(OVF & IRQEN)
countgen_io  inout  NUM_CH  channel pins; driven when DIR bit=1, else Z

Behaviour:
- Reset (rst_i=0 at posedge) clears every register:
  - dat_o=0, ack_o=0, irq_o=0, all pins Z.
  - DIR, MODE, PERIOD, COUNT, SNAP, OVF, IRQEN all 0; generator outputs and dividers 0; synchronisers 0.
  - Reset mid-transfer drops ack_o the next cycle and aborts the transfer.
- Bus handshake:
  - ack_o <= cyc_i & stb_i & ~ack_o, so each access gives a 1-cycle ack, 1 cycle after strobe.
  - A write takes effect on the cycle ack_o is registered; dat_o is loaded on that same edge.
  - Unmapped addresses and channel index >= NUM_CH read 0 and ignore writes.
- Global map (adr_i[7]=0):
  - 0x00 DIR: 1 = output.
  - 0x01 SNAPCMD: write-1 bits copy COUNT->SNAP for those channels, atomically in one cycle; reads 0.
  - 0x02 CLRCMD: write-1 bits zero COUNT; reads 0.
  - 0x03 OVF: sticky; write-1-to-clear.
  - 0x04 IRQEN.
- Channel map (adr_i[7]=1, ch=adr_i[6:2], reg=adr_i[1:0]):
  - 0 MODE: [1:0] edge select (00 off, 01 rise, 10 fall, 11 both); [2] generator enable.
  - 1 PERIOD: half-period in clk ticks.
  - 2 COUNT: R/W live counter.
  - 3 SNAP: read-only.
- Generator per channel:
  - Divider counts 0..PERIOD-1; on terminal count the output toggles and the divider reloads 0.
  - Full period = 2*PERIOD clocks.
  - Enable=0 or PERIOD=0: output held 0, divider held 0.
  - Writing PERIOD zeroes the divider and leaves the output level unchanged.
- Count path per channel:
  - Source is the pin when DIR=0, or the internal generator output when DIR=1 (loopback).
  - Source passes a 2-FF synchroniser, then a registered previous-value stage for edge detect.
  - A pin edge before posedge N increments COUNT at posedge N+3.
  - Mode 00 never counts.
  - DIR change resets nothing; a spurious edge from the source switch is counted if the mode selects it.
- Wrap and overflow: COUNT at 2^CNT_W-1 plus an edge gives 0 and sets OVF[ch].
- Same-cycle priority on COUNT: CLRCMD > bus write to COUNT > edge increment.
- Other same-cycle events:
  - SNAPCMD with an edge: SNAP takes the pre-increment value.
  - OVF clear with a new overflow: set wins.
  - SNAPCMD with CLRCMD on the same channel cannot occur (different addresses).
- Arithmetic is unsigned, modulo 2^CNT_W. Bus writes to CNT_W-wide registers use dat_i[CNT_W-1:0].

Test Plan:
- Reset/bus: hold rst_i=0 3 cycles, release, then read 0x00, 0x80, 0x82 -> all read 0x0; each ack_o is exactly 1 cycle, 1 cycle after stb; read 0xFC with NUM_CH=8 -> 0x0.
- Generator: DIR=0x01, ch0 MODE=0x4, PERIOD=3 -> countgen_io[0] toggles every 3 clocks (period 6); write PERIOD=0 -> pin held 0 within 1 cycle; other pins stay Z.
- Edge modes: with DIR=0, drive 5 pulses on pin 2 under each of MODE 01/10/11/00 -> COUNT reads 5/5/10/0; first increment lands 3 clocks after the edge.
- Loopback + snapshot: ch1 DIR=1, MODE=0x5, PERIOD=2, run 40 clocks, SNAPCMD=0x02 -> SNAP in 9..10, COUNT keeps advancing past SNAP.
- Overflow/IRQ: CNT_W=8, write COUNT=0xFF, IRQEN=0x01, one rising edge -> COUNT=0x00, OVF=0x01, irq_o=1; write OVF=0x01 -> irq_o=0 next cycle.
- Collisions: force CLRCMD and an edge in the same cycle -> COUNT=0; force a COUNT write of 0x10 with an edge -> COUNT=0x10; force SNAPCMD with an edge at COUNT=7 -> SNAP=7, COUNT=8.
